// File: rtl/dpram_port_initiator_if.sv
// Bundle of command, RAM-port and response signals for dpram_port_initiator.
// The master modport is the initiator side; slave is the surrounding traffic/RAM environment.
interface dpram_port_initiator_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_q;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_data,
    output cmd_ready,
    output mem_valid, mem_we, mem_addr, mem_data,
    input  mem_ready, mem_q,
    output rsp_valid, rsp_we, rsp_addr, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_data,
    input  cmd_ready,
    input  mem_valid, mem_we, mem_addr, mem_data,
    output mem_ready, mem_q,
    input  rsp_valid, rsp_we, rsp_addr, rsp_data, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/dpram_port_initiator.sv
// Single-outstanding initiator for one valid/ready RAM port with an in-order response FIFO.
// Optional request watchdog (TIMEOUT_CYC cycles) enabled by defining DPRAM_INIT_TIMEOUT_EN.
module dpram_port_initiator #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int RSP_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dpram_port_initiator_if.master bus,
  output logic                   busy,
  output logic [15:0]            txn_count
);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("dpram_port_initiator: RSP_DEPTH must be a power of 2 >= 2, TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, CAPT = 2'd2} state_t;

  state_t             state, state_nxt;
  logic               accept, handshake, timeout, push, pop;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENT_W-1:0]   rsp_mem [RSP_DEPTH];
  logic [ENT_W-1:0]   head;

  assign accept    = bus.cmd_valid & bus.cmd_ready;
  assign handshake = (state == REQ) & bus.mem_ready;
  // A watchdog expiry pushes its error response directly from REQ.
  assign push      = (state == CAPT) | timeout;
  assign pop       = bus.rsp_valid & bus.rsp_ready;

`ifdef DPRAM_INIT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_mem [RSP_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_cnt <= '0;
    else if (state != REQ)     to_cnt <= '0;
    else if (!bus.mem_ready)   to_cnt <= to_cnt + 1'b1;
  end

  // handshake has priority: the limit only fires while mem_ready is low
  assign timeout = (state == REQ) & ~bus.mem_ready & (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (push) err_mem[wr_ptr] <= timeout;
  end

  assign bus.rsp_err = bus.rsp_valid & err_mem[rd_ptr];
`else
  assign timeout     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ: begin
        if (handshake)    state_nxt = CAPT;
        else if (timeout) state_nxt = IDLE;
      end
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.mem_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: bus.cmd_ready = rst_n & (count < DEPTH_C);
      REQ: begin
        bus.mem_valid = 1'b1;
        busy          = 1'b1;
      end
      CAPT:    busy = 1'b1;
      default: ;
    endcase
  end

  // Request fields are latched on accept and held through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
    end else if (accept) begin
      bus.mem_we   <= bus.cmd_we;
      bus.mem_addr <= bus.cmd_addr;
      bus.mem_data <= bus.cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    txn_count <= '0;
    else if (push) txn_count <= txn_count + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) rsp_mem[wr_ptr] <= {bus.mem_we, bus.mem_addr, timeout ? {DATA_W{1'b0}} : bus.mem_q};
  end

  // Storage is not reset; outputs read as zero while the FIFO is empty.
  assign head          = rsp_mem[rd_ptr];
  assign bus.rsp_valid = (count != '0);
  assign {bus.rsp_we, bus.rsp_addr, bus.rsp_data} = bus.rsp_valid ? head : {ENT_W{1'b0}};
endmodule

// File: tb/tb_dpram_port_initiator.sv
// Self-checking bench for dpram_port_initiator: behavioural RAM model plus response scoreboard.
// The watchdog scenario is exercised only when DPRAM_INIT_TIMEOUT_EN is defined.
module tb_dpram_port_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] txn_count;

  typedef struct packed {
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  rsp_t       exp_q [$];
  rsp_t       sb_exp, sb_obs;
  logic [7:0] ref_mem [64];
  logic [7:0] ram [64];
  logic       expect_err = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         rsp_seen = 0;
  int         hs_count = 0;

  dpram_port_initiator_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  dpram_port_initiator #(
    .ADDR_W(6), .DATA_W(8), .RSP_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // RAM port model with a registered q output
  always @(posedge clk) begin
    if (bus.mem_valid && bus.mem_ready) begin
      hs_count <= hs_count + 1;
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_data;
        bus.mem_q         <= bus.mem_data;
      end else begin
        bus.mem_q <= ram[bus.mem_addr];
      end
    end
  end

  // Scoreboard: push on command handshake, compare on response pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        sb_exp.we   = bus.cmd_we;
        sb_exp.addr = bus.cmd_addr;
        sb_exp.data = expect_err ? 8'h00 : (bus.cmd_we ? bus.cmd_data : ref_mem[bus.cmd_addr]);
        sb_exp.err  = expect_err;
        if (bus.cmd_we && !expect_err) ref_mem[bus.cmd_addr] = bus.cmd_data;
        exp_q.push_back(sb_exp);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_seen++;
        vectors++;
        sb_obs = {bus.rsp_we, bus.rsp_addr, bus.rsp_data, bus.rsp_err};
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got we=%0b addr=%h data=%h err=%0b, none expected",
                   sb_obs.we, sb_obs.addr, sb_obs.data, sb_obs.err);
        end else begin
          sb_exp = exp_q.pop_front();
          if (sb_obs !== sb_exp) begin
            miscompares++;
            $display("FAIL sb_rsp: got we=%0b addr=%h data=%h err=%0b, expected we=%0b addr=%h data=%h err=%0b",
                     sb_obs.we, sb_obs.addr, sb_obs.data, sb_obs.err,
                     sb_exp.we, sb_exp.addr, sb_exp.data, sb_exp.err);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(2);
    vectors++;
    if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_data, bus.cmd_ready, busy} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_mem: got valid=%0b we=%0b addr=%h data=%h cmd_ready=%0b busy=%0b, expected all 0",
               bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_data, bus.cmd_ready, busy);
    end
    vectors++;
    if ({bus.rsp_valid, bus.rsp_we, bus.rsp_addr, bus.rsp_data, bus.rsp_err, txn_count} !== 33'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: got rsp_valid=%0b addr=%h data=%h txn=%0d, expected 0",
               bus.rsp_valid, bus.rsp_addr, bus.rsp_data, txn_count);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_write;
    bus.mem_ready = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.cmd_we = 1'b1; bus.cmd_addr = 6'h05; bus.cmd_data = 8'hA5; bus.cmd_valid = 1'b1;
    step(1);
    vectors++;
    if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_data, busy, bus.cmd_ready} !== {1'b1, 1'b1, 6'h05, 8'hA5, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL write_req: got valid=%0b we=%0b addr=%h data=%h busy=%0b cmd_ready=%0b, expected 1 1 05 a5 1 0",
               bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_data, busy, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b0;
    step(1);
    vectors++;
    if ({bus.mem_valid, bus.rsp_valid, busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL write_capt: got mem_valid=%0b rsp_valid=%0b busy=%0b, expected 0 0 1",
               bus.mem_valid, bus.rsp_valid, busy);
    end
    step(1);
    vectors++;
    if ({bus.rsp_valid, bus.rsp_we, bus.rsp_addr, bus.rsp_data, bus.rsp_err, txn_count, busy} !== {1'b1, 1'b1, 6'h05, 8'hA5, 1'b0, 16'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL write_rsp: got valid=%0b we=%0b addr=%h data=%h err=%0b txn=%0d busy=%0b, expected 1 1 05 a5 0 1 0",
               bus.rsp_valid, bus.rsp_we, bus.rsp_addr, bus.rsp_data, bus.rsp_err, txn_count, busy);
    end
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    vectors++;
    if ({bus.rsp_valid, rsp_seen} !== {1'b0, 32'd1}) begin
      miscompares++;
      $display("FAIL write_pop: got rsp_valid=%0b seen=%0d, expected 0 1", bus.rsp_valid, rsp_seen);
    end
  endtask

  task automatic test_read;
    bus.cmd_we = 1'b0; bus.cmd_addr = 6'h05; bus.cmd_data = 8'hFF; bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    vectors++;
    if ({bus.mem_valid, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 6'h05}) begin
      miscompares++;
      $display("FAIL read_req: got valid=%0b we=%0b addr=%h, expected 1 0 05",
               bus.mem_valid, bus.mem_we, bus.mem_addr);
    end
    step(2);
    vectors++;
    if ({bus.rsp_valid, bus.rsp_we, bus.rsp_addr, bus.rsp_data, txn_count} !== {1'b1, 1'b0, 6'h05, 8'hA5, 16'd2}) begin
      miscompares++;
      $display("FAIL read_rsp: got valid=%0b we=%0b addr=%h data=%h txn=%0d, expected 1 0 05 a5 2",
               bus.rsp_valid, bus.rsp_we, bus.rsp_addr, bus.rsp_data, txn_count);
    end
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_stall;
    int hs0 = hs_count;
    int stable = 0;
    bus.mem_ready = 1'b0;
    bus.cmd_we = 1'b1; bus.cmd_addr = 6'h12; bus.cmd_data = 8'h3C; bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = 6'h00; bus.cmd_data = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_data} === {1'b1, 1'b1, 6'h12, 8'h3C}) stable++;
      if (i < 5) step(1);
    end
    vectors++;
    if (stable !== 6) begin
      miscompares++;
      $display("FAIL stall_hold: got %0d stable cycles, expected 6", stable);
    end
    bus.mem_ready = 1'b1;
    step(1);
    vectors++;
    if ({bus.mem_valid, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_release: got mem_valid=%0b busy=%0b, expected 0 1", bus.mem_valid, busy);
    end
    step(1);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    vectors++;
    if ({hs_count - hs0, rsp_seen, txn_count} !== {32'd1, 32'd3, 16'd3}) begin
      miscompares++;
      $display("FAIL stall_once: got handshakes=%0d responses=%0d txn=%0d, expected 1 3 3",
               hs_count - hs0, rsp_seen, txn_count);
    end
  endtask

  task automatic test_fifo_full;
    int   acc = 0;
    int   seen0 = rsp_seen;
    logic take;
    bus.mem_ready = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.cmd_we = 1'b1; bus.cmd_addr = 6'h20; bus.cmd_data = 8'h80; bus.cmd_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk) take = bus.cmd_ready;
      step(1);
      if (take) begin
        acc++;
        bus.cmd_addr = 6'(32 + acc);
        bus.cmd_data = 8'(128 + acc);
      end
    end
    vectors++;
    if ({acc, bus.cmd_ready, busy, bus.rsp_valid, bus.rsp_addr} !== {32'd4, 1'b0, 1'b0, 1'b1, 6'h20}) begin
      miscompares++;
      $display("FAIL fifo_full: got accepted=%0d cmd_ready=%0b busy=%0b rsp_valid=%0b head=%h, expected 4 0 0 1 20",
               acc, bus.cmd_ready, busy, bus.rsp_valid, bus.rsp_addr);
    end
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_free: got cmd_ready=%0b after pop, expected 1", bus.cmd_ready);
    end
    for (int c = 0; c < 10 && acc < 5; c++) begin
      @(negedge clk) take = bus.cmd_ready;
      step(1);
      if (take) acc++;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 30 && (rsp_seen - seen0) < 5; c++) step(1);
    bus.rsp_ready = 1'b0;
    vectors++;
    if ({acc, rsp_seen - seen0, txn_count} !== {32'd5, 32'd5, 16'd8}) begin
      miscompares++;
      $display("FAIL fifo_drain: got accepted=%0d responses=%0d txn=%0d, expected 5 5 8",
               acc, rsp_seen - seen0, txn_count);
    end
  endtask

  task automatic test_reset_inflight;
    int seen0;
    bus.mem_ready = 1'b0;
    bus.cmd_we = 1'b0; bus.cmd_addr = 6'h05; bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.mem_valid, bus.rsp_valid, busy, bus.cmd_ready, txn_count} !== 20'h0) begin
      miscompares++;
      $display("FAIL rst_inflight: got mem_valid=%0b rsp_valid=%0b busy=%0b cmd_ready=%0b txn=%0d, expected 0",
               bus.mem_valid, bus.rsp_valid, busy, bus.cmd_ready, txn_count);
    end
    exp_q.delete();
    step(1);
    rst_n = 1'b1;
    seen0 = rsp_seen;
    bus.mem_ready = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.cmd_we = 1'b1; bus.cmd_addr = 6'h0A; bus.cmd_data = 8'h5A; bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 20 && rsp_seen == seen0; c++) step(1);
    bus.rsp_ready = 1'b0;
    vectors++;
    if ({rsp_seen - seen0, txn_count} !== {32'd1, 16'd1}) begin
      miscompares++;
      $display("FAIL rst_fresh: got responses=%0d txn=%0d, expected 1 1", rsp_seen - seen0, txn_count);
    end
  endtask

`ifdef DPRAM_INIT_TIMEOUT_EN
  task automatic test_timeout;
    int hi = 0;
    int seen0;
    bus.mem_ready = 1'b0;
    bus.rsp_ready = 1'b0;
    expect_err = 1'b1;
    bus.cmd_we = 1'b0; bus.cmd_addr = 6'h3F; bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    expect_err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!bus.mem_valid) break;
      hi++;
      step(1);
    end
    vectors++;
    if (hi !== 16) begin
      miscompares++;
      $display("FAIL to_len: got mem_valid high %0d cycles, expected 16", hi);
    end
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_we, bus.rsp_addr, bus.rsp_data, txn_count, bus.cmd_ready} !== {1'b1, 1'b1, 1'b0, 6'h3F, 8'h00, 16'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL to_rsp: got valid=%0b err=%0b we=%0b addr=%h data=%h txn=%0d cmd_ready=%0b, expected 1 1 0 3f 00 2 1",
               bus.rsp_valid, bus.rsp_err, bus.rsp_we, bus.rsp_addr, bus.rsp_data, txn_count, bus.cmd_ready);
    end
    seen0 = rsp_seen;
    bus.mem_ready = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.cmd_we = 1'b1; bus.cmd_addr = 6'h3F; bus.cmd_data = 8'h77; bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 20 && (rsp_seen - seen0) < 2; c++) step(1);
    bus.rsp_ready = 1'b0;
    vectors++;
    if ({rsp_seen - seen0, txn_count} !== {32'd2, 16'd3}) begin
      miscompares++;
      $display("FAIL to_next: got responses=%0d txn=%0d, expected 2 3", rsp_seen - seen0, txn_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.mem_ready = 1'b0; bus.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_fifo_full();
    test_reset_inflight();
`ifdef DPRAM_INIT_TIMEOUT_EN
    test_timeout();
`endif
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d pending responses, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dpram_port_initiator.md
Name: dpram_port_initiator

Overview:
Initiator for one valid/ready port of the team's dual-port RAM.
- Accepts read/write commands on an upstream valid/ready interface and drives the RAM port signals (valid, we, addr, data).
- Waits for the RAM's ready, captures the registered q the cycle after the handshake, and queues the result in a response FIFO for downstream consumers.
- Instantiated once per RAM port in test/traffic subsystems.

Parameters:
ADDR_W, 6, RAM address width
DATA_W, 8, RAM data width
RSP_DEPTH, 4, response FIFO entries; power of 2, >=2
TIMEOUT_CYC, 16, watchdog limit in cycles; used only with the optional feature

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_we  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_data  in  DATA_W  write data; ignored for reads
mem_valid  out  1  request to RAM port
mem_ready  in  1  RAM port can accept
mem_we  out  1  to RAM we
mem_addr  out  ADDR_W  to RAM addr
mem_data  out  DATA_W  to RAM data
mem_q  in  DATA_W  RAM registered output
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  consumer pops head
rsp_we  out  1  echo of command type
rsp_addr  out  ADDR_W  echo of command address
rsp_data  out  DATA_W  captured mem_q (read data, or write echo)
rsp_err  out  1  transaction aborted; tied 0 without the optional feature
busy  out  1  state != IDLE
txn_count  out  16  completed transactions (including aborted), wraps 0xFFFF->0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; mem_valid=0, mem_we=0, mem_addr=0, mem_data=0; FIFO flushed (rsp_valid=0; rsp_* = 0); txn_count=0; busy=0; cmd_ready=0 while rst_n low. A transaction in flight is discarded with no response. mem_valid falls immediately on reset assertion, without waiting for a clock edge.
- FSM states are IDLE, REQ and CAPT.
- IDLE:
  - cmd_ready = (FIFO count < RSP_DEPTH).
  - On an edge with cmd_valid & cmd_ready: latch we/addr/data into mem_*, set mem_valid=1, go to REQ.
- REQ:
  - mem_valid, mem_we, mem_addr and mem_data are held stable until an edge samples mem_ready=1.
  - At that edge: mem_valid<=0, go to CAPT.
  - cmd_ready=0.
- CAPT:
  - At the next edge, push {mem_we, mem_addr, mem_q, err=0} into the FIFO, increment txn_count, return to IDLE.
  - cmd_ready=0.
- Latency with mem_ready=1: the accept edge is E0, the handshake is E1, the push is E2, and rsp_valid is high after E2. Maximum throughput is one command per 3 cycles.
- A FIFO slot is always free at push, because acceptance requires count<RSP_DEPTH and only one transaction is ever in flight.
- FIFO:
  - Pop on edge with rsp_valid & rsp_ready. rsp_* shows the head combinationally from storage.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pointers wrap modulo RSP_DEPTH.
  - Pop when empty is ignored.
- Write responses return mem_q, which must equal the written data.
- cmd_* changes while cmd_ready=0 have no effect.

Optional Feature:
Macro DPRAM_INIT_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ with mem_ready=0.
  - When the counter reaches TIMEOUT_CYC without a handshake: mem_valid<=0, then push {mem_we, mem_addr, data=0, err=1} directly (skipping CAPT), increment txn_count, go to IDLE.
  - The counter clears on entering REQ.
  - A handshake on the same edge as the limit wins (normal completion).
- Undefined: no counter; REQ waits indefinitely; rsp_err constant 0.

Test Plan:
- Write addr 0x05 data 0xA5, mem_ready=1 -> mem_valid high exactly 1 cycle with mem_addr=0x05, mem_data=0xA5; rsp_valid 2 edges after accept with rsp_we=1, rsp_addr=0x05, rsp_data=0xA5; txn_count=1.
- Read addr 0x05 after the write above -> mem_we=0; rsp_data=0xA5, rsp_we=0.
- mem_ready held 0 for 5 cycles after mem_valid rises -> mem_valid/addr/data stable for 6 cycles; exactly one handshake; one response.
- rsp_ready=0, RSP_DEPTH=4, 5 writes offered back-to-back -> 4 responses queued, cmd_ready=0 in IDLE; pop one -> cmd_ready=1, 5th accepted; responses come out in order.
- rst_n pulsed low while in REQ -> mem_valid=0 immediately, rsp_valid=0, txn_count=0, busy=0; a fresh write after reset completes normally.
- With DPRAM_INIT_TIMEOUT_EN, TIMEOUT_CYC=16, mem_ready stuck 0 on a read of addr 0x3F -> mem_valid drops after 16 cycles; response rsp_err=1, rsp_data=0x00, rsp_addr=0x3F; next command is accepted.
